conv_window_sched: RTL

- Sequencer for the single-window convolution engine.
- On start, raster-scans all OUT x OUT output positions and issues one window request per position over a valid/ready handshake.
- Waits for each engine result and writes it to the result store at row-major address row*OUT+col.
- Replaces ad-hoc top-level stepping with a reusable, abortable scheduler.

---
 rtl/conv_window_sched_if.sv | 47 ++++
 rtl/conv_window_sched.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/conv_window_sched_if.sv
// conv_window_sched_if
//   Bundles the scheduler's three traffic groups: window requests to the
//   convolution engine, results coming back from the engine, and writes
//   into the result store.
//
//   Parameters: ADDR_W (result address width), RES_W (result word width).
//
//   master modport (scheduler side):
//     out win_valid, win_row[7:0], win_col[7:0], win_new_row
//     in  win_ready
//     in  res_valid, res_data[RES_W-1:0]
//     out res_ready
//     out wr_en, wr_addr[ADDR_W-1:0], wr_data[RES_W-1:0]
//   slave modport: the same signals, directions reversed.

interface conv_window_sched_if #(
    parameter int ADDR_W = 8,
    parameter int RES_W  = 16
);
    logic              win_valid;
    logic              win_ready;
    logic [7:0]        win_row;
    logic [7:0]        win_col;
    logic              win_new_row;
    logic              res_valid;
    logic [RES_W-1:0]  res_data;
    logic              res_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [RES_W-1:0]  wr_data;

    modport master (
        output win_valid, win_row, win_col, win_new_row,
        input  win_ready,
        input  res_valid, res_data,
        output res_ready,
        output wr_en, wr_addr, wr_data
    );

    modport slave (
        input  win_valid, win_row, win_col, win_new_row,
        output win_ready,
        output res_valid, res_data,
        input  res_ready,
        input  wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/conv_window_sched.sv
// conv_window_sched
//   Job sequencer for the single-window convolution engine. On start it
//   raster-scans every OUT x OUT output position, issues one window request
//   per position, waits for the engine result and writes it to the result
//   store at address row*OUT+col. A job can be aborted at any point while
//   it is running.
//
//   Ports:
//     clk        in   rising-edge clock
//     rst        in   synchronous, active-high reset
//     start      in   begin a job (only looked at in IDLE)
//     abort      in   cancel the running job (ISSUE/WAIT/WRITE)
//     busy       out  job in progress (ISSUE/WAIT/WRITE)
//     done       out  one-cycle pulse after the last write of a full job
//     aborted    out  one-cycle pulse, the cycle after abort is taken
//     err        out  sticky: result arrived while not in WAIT
//     bus        master side of conv_window_sched_if (window request,
//                engine result, result-store write)
//   Optional (macro CONV_SCHED_PERF_EN):
//     cyc_cnt    out  busy cycles of the current/last job, saturating
//     stall_cnt  out  ISSUE cycles without win_ready plus WAIT cycles
//                     without res_valid, saturating
//
//   state  | meaning
//   IDLE   | waiting for start
//   ISSUE  | window request valid, waiting for win_ready
//   WAIT   | res_ready high, waiting for the engine result
//   WRITE  | writing captured result, stepping to next position
//   FIN    | done pulse, back to IDLE

module conv_window_sched #(
    parameter int IMAGE_WIDTH  = 5,
    parameter int IMAGE_HEIGHT = 5,
    parameter int FILTER_SIZE  = 3,
    parameter int OUT          = IMAGE_HEIGHT - FILTER_SIZE + 1,
    parameter int ADDR_W       = 8,
    parameter int RES_W        = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic abort,
    output logic busy,
    output logic done,
    output logic aborted,
    output logic err,
`ifdef CONV_SCHED_PERF_EN
    output logic [31:0] cyc_cnt,
    output logic [31:0] stall_cnt,
`endif
    conv_window_sched_if.master bus
);

    // The scan only uses OUT (derived from the height); a non-square image
    // or an address space too small for OUT*OUT results is a build error.
    if (IMAGE_WIDTH != IMAGE_HEIGHT || OUT < 1 || OUT > 255 ||
        (OUT * OUT - 1) >= (1 << ADDR_W)) begin : g_bad_cfg
        $error("conv_window_sched: illegal geometry parameters");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_WRITE,
        S_FIN
    } state_t;

    localparam logic [7:0] LAST = 8'(OUT - 1);

    state_t           state_q, state_d;
    logic [7:0]       row_q, row_d;
    logic [7:0]       col_q, col_d;
    logic [RES_W-1:0] data_q;
    logic             err_q;
    logic             aborted_q;
    logic             start_acc;
    logic             in_job;
    logic             abort_acc;

    assign start_acc = (state_q == S_IDLE) && start;
    assign in_job    = (state_q == S_ISSUE) || (state_q == S_WAIT) ||
                       (state_q == S_WRITE);
    assign abort_acc = in_job && abort;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            row_q     <= '0;
            col_q     <= '0;
            data_q    <= '0;
            err_q     <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            aborted_q <= abort_acc;
            if (state_q == S_WAIT && bus.res_valid && !abort)
                data_q <= bus.res_data;
            // A stray result in the same cycle as an accepted start still
            // flags, so the error is never silently lost.
            err_q <= (err_q && !start_acc) ||
                     (bus.res_valid && state_q != S_WAIT);
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ISSUE;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            S_ISSUE: begin
                if (abort)
                    state_d = S_IDLE;
                else if (bus.win_ready)
                    state_d = S_WAIT;
            end
            S_WAIT: begin
                if (abort)
                    state_d = S_IDLE;
                else if (bus.res_valid)
                    state_d = S_WRITE;
            end
            S_WRITE: begin
                // The write strobe is driven from the state, so an abort
                // here still lets this cycle's write through.
                if (abort) begin
                    state_d = S_IDLE;
                end else if (row_q == LAST && col_q == LAST) begin
                    state_d = S_FIN;
                end else if (col_q == LAST) begin
                    state_d = S_ISSUE;
                    col_d   = '0;
                    row_d   = row_q + 8'd1;
                end else begin
                    state_d = S_ISSUE;
                    col_d   = col_q + 8'd1;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy    = in_job;
    assign done    = (state_q == S_FIN);
    assign aborted = aborted_q;
    assign err     = err_q;

    assign bus.win_valid   = (state_q == S_ISSUE);
    assign bus.win_row     = row_q;
    assign bus.win_col     = col_q;
    assign bus.win_new_row = (state_q == S_ISSUE) && (col_q == 8'd0);
    assign bus.res_ready   = (state_q == S_WAIT);
    assign bus.wr_en       = (state_q == S_WRITE);
    assign bus.wr_addr     = ADDR_W'(row_q) * ADDR_W'(OUT) + ADDR_W'(col_q);
    assign bus.wr_data     = data_q;

`ifdef CONV_SCHED_PERF_EN
    logic [31:0] cyc_q;
    logic [31:0] stall_q;
    logic        stall_now;

    assign stall_now = (state_q == S_ISSUE && !bus.win_ready) ||
                       (state_q == S_WAIT  && !bus.res_valid);

    // Counting only while busy freezes both counters at FIN or abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q   <= '0;
            stall_q <= '0;
        end else if (start_acc) begin
            cyc_q   <= '0;
            stall_q <= '0;
        end else begin
            if (in_job && cyc_q != '1)
                cyc_q <= cyc_q + 32'd1;
            if (stall_now && stall_q != '1)
                stall_q <= stall_q + 32'd1;
        end
    end

    assign cyc_cnt   = cyc_q;
    assign stall_cnt = stall_q;
`endif

endmodule
